// File: rtl/tero_pkg.sv
// Shared definitions for the TERO scheduler: FSM state encoding, tag width
// and watchdog defaults.
package tero_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_OSC   = 3'd2;
  localparam logic [2:0] S_EMIT  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_STEP  = 3'd5;
  localparam logic [2:0] S_NEXT  = 3'd6;
  localparam logic [2:0] S_FIN   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_ARM   = S_ARM,
    ST_OSC   = S_OSC,
    ST_EMIT  = S_EMIT,
    ST_DRAIN = S_DRAIN,
    ST_STEP  = S_STEP,
    ST_NEXT  = S_NEXT,
    ST_FIN   = S_FIN
  } state_t;

  localparam int TAG_W       = 3;
  localparam int CNT_W       = 12;
  localparam int TIMEOUT_DEF = 4095;

endpackage

// File: rtl/tero_watchdog.sv
// OSC-phase cycle counter: cleared before each oscillation, counts while
// enabled and flags expiry on the cycle the count reaches the limit.
module tero_watchdog #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt counts completed OSC cycles, so the limit-th cycle sees limit-1
  assign expire = enable && (cnt == limit - 1'b1);

endmodule

// File: rtl/tero_sched.sv
// Round-robin TERO unit scheduler feeding one serializer path.
// Optional OSC watchdog enabled by defining TERO_SCHED_TIMEOUT_EN.
module tero_sched
  import tero_pkg::*;
#(
  parameter int NUM_UNIT = 4,
  parameter int SEL_W    = 20,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  FIXED,
  input  logic [SEL_W-1:0]      SEL_INIT,
  input  logic [SEL_W-1:0]      SEL_LAST,
  input  logic [11:0]           SAMPLES,
  input  logic [NUM_UNIT-1:0]   UNIT_OE,
  input  logic [8*NUM_UNIT-1:0] UNIT_OUT,
  input  logic                  UART_FULL,
  input  logic                  UART_EMPTY,
  output logic [NUM_UNIT-1:0]   CTR,
  output logic [SEL_W-1:0]      RO_SEL,
  output logic [7:0]            DOUT,
  output logic [TAG_W-1:0]      DTAG,
  output logic                  OE,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [NUM_UNIT-1:0]   FAULT
);

  localparam int UW = (NUM_UNIT > 1) ? $clog2(NUM_UNIT) : 1;

  if (NUM_UNIT < 2 || NUM_UNIT > 8 || TIMEOUT < 1 || TIMEOUT > 4095) begin : g_bad_cfg
    $error("tero_sched: NUM_UNIT must be 2..8 and TIMEOUT 1..4095");
  end

  state_t          state;
  logic [UW-1:0]   u;
  logic [CNT_W-1:0] r;
  logic            wrap;
  logic [7:0]      unit_byte [NUM_UNIT];

  for (genvar g = 0; g < NUM_UNIT; g++) begin : g_byte
    assign unit_byte[g] = UNIT_OUT[8*g +: 8];
  end

  assign wrap = (u == UW'(NUM_UNIT - 1));

`ifdef TERO_SCHED_TIMEOUT_EN
  logic                wd_expire;
  logic [NUM_UNIT-1:0] fault;

  tero_watchdog #(
    .W(CNT_W)
  ) u_watchdog (
    .clk   (CLK),
    .rst   (RST),
    .clear (state == ST_ARM),
    .enable(state == ST_OSC),
    .limit (CNT_W'(TIMEOUT)),
    .expire(wd_expire)
  );

  assign FAULT = fault;
`else
  assign FAULT = '0;
`endif

  // All outputs are registered; each is updated on the transition into the
  // state that owns it, so CTR drops and OE rises on the same edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= ST_IDLE;
      u      <= '0;
      r      <= '0;
      CTR    <= '0;
      RO_SEL <= '0;
      DOUT   <= '0;
      DTAG   <= '0;
      OE     <= 1'b0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
`ifdef TERO_SCHED_TIMEOUT_EN
      fault  <= '0;
`endif
    end else begin
      OE <= 1'b0;
      case (state)
        ST_IDLE: begin
          BUSY <= 1'b0;
          DONE <= 1'b0;
          if (START) begin
            RO_SEL <= SEL_INIT;
            u      <= '0;
            r      <= '0;
`ifdef TERO_SCHED_TIMEOUT_EN
            fault  <= '0;
`endif
            BUSY   <= 1'b1;
            state  <= ST_ARM;
          end
        end
        ST_ARM: begin
          CTR   <= NUM_UNIT'(1) << u;
          state <= ST_OSC;
        end
        ST_OSC: begin
          if (UNIT_OE[u]) begin
            CTR   <= '0;
            DOUT  <= unit_byte[u];
            DTAG  <= TAG_W'(u);
            OE    <= 1'b1;
            state <= ST_EMIT;
          end
`ifdef TERO_SCHED_TIMEOUT_EN
          else if (wd_expire) begin
            CTR      <= '0;
            fault[u] <= 1'b1;
            state    <= ST_STEP;
          end
`endif
        end
        ST_EMIT: begin
          state <= UART_FULL ? ST_DRAIN : ST_STEP;
        end
        ST_DRAIN: begin
          if (!UART_FULL && UART_EMPTY) begin
            state <= ST_STEP;
          end
        end
        ST_STEP: begin
          u <= wrap ? '0 : u + 1'b1;
          if (wrap) begin
            r <= r + 1'b1;
          end
          if (!START) begin
            BUSY  <= 1'b0;
            state <= ST_IDLE;
          end else if (wrap && (r == SAMPLES) && !FIXED) begin
            state <= ST_NEXT;
          end else begin
            state <= ST_ARM;
          end
        end
        ST_NEXT: begin
          if (RO_SEL == SEL_LAST) begin
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
            state <= ST_FIN;
          end else begin
            RO_SEL <= RO_SEL + 1'b1;
            r      <= '0;
            state  <= ST_ARM;
          end
        end
        ST_FIN: begin
          if (!START) begin
            DONE  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tero_sched.sv
// Randomized bench for tero_sched: modelled TERO units plus an expected
// write sequence derived from the sweep rules.
module tb_tero_sched;

  localparam int N  = 4;
  localparam int SW = 20;
`ifdef TERO_SCHED_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 4095;
`endif

  logic            CLK;
  logic            RST;
  logic            START;
  logic            FIXED;
  logic [SW-1:0]   SEL_INIT;
  logic [SW-1:0]   SEL_LAST;
  logic [11:0]     SAMPLES;
  logic [N-1:0]    UNIT_OE;
  logic [8*N-1:0]  UNIT_OUT;
  logic            UART_FULL;
  logic            UART_EMPTY;
  logic [N-1:0]    CTR;
  logic [SW-1:0]   RO_SEL;
  logic [7:0]      DOUT;
  logic [2:0]      DTAG;
  logic            OE;
  logic            BUSY;
  logic            DONE;
  logic [N-1:0]    FAULT;

  tero_sched #(
    .NUM_UNIT(N),
    .SEL_W   (SW),
    .TIMEOUT (TO)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .FIXED     (FIXED),
    .SEL_INIT  (SEL_INIT),
    .SEL_LAST  (SEL_LAST),
    .SAMPLES   (SAMPLES),
    .UNIT_OE   (UNIT_OE),
    .UNIT_OUT  (UNIT_OUT),
    .UART_FULL (UART_FULL),
    .UART_EMPTY(UART_EMPTY),
    .CTR       (CTR),
    .RO_SEL    (RO_SEL),
    .DOUT      (DOUT),
    .DTAG      (DTAG),
    .OE        (OE),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .FAULT     (FAULT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int tag;
    int sel;
  } exp_t;

  exp_t       exp_q[$];
  int         checks, errors, cyc, oe_cnt;
  logic [7:0] fire_byte [N];
  int         fire_cyc [N];
  int         age [N];
  int         delay [N];
  bit         mute [N];
  bit         rand_delay, rand_bp, junk_en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected writes: for each RO_SEL value, SAMPLES+1 rounds over all units
  task automatic expect_run(input int init, input int last, input int samples,
                            input bit fixed, input int skip);
    int s;
    exp_t e;
    s = init;
    if (fixed) begin
      for (int k = 0; k < 50; k++)
        for (int j = 0; j < N; j++) begin
          e.tag = j; e.sel = s; exp_q.push_back(e);
        end
    end else begin
      forever begin
        for (int k = 0; k <= samples; k++)
          for (int j = 0; j < N; j++)
            if (j != skip) begin
              e.tag = j; e.sel = s; exp_q.push_back(e);
            end
        if (s == last) break;
        s = (s + 1) & 32'hFFFFF;
      end
    end
  endtask

  task automatic cycle();
    exp_t e;
    bit   bp;
    @(posedge CLK);
    #1;
    cyc++;
    check("ctr_onehot", 32'($countones(CTR) <= 1), 32'd1);
    if (OE) begin
      oe_cnt++;
      if (exp_q.size() == 0) begin
        check("oe_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("dtag", 32'(DTAG), e.tag);
        check("dout", 32'(DOUT), 32'(fire_byte[e.tag]));
        check("ro_sel", 32'(RO_SEL), e.sel);
        check("oe_latency", cyc, fire_cyc[e.tag] + 1);
        check("ctr_off_in_emit", 32'(CTR), 32'd0);
        check("busy_in_emit", 32'(BUSY), 32'd1);
      end
    end
    UNIT_OE = '0;
    for (int i = 0; i < N; i++) begin
      if (CTR[i]) begin
        age[i]++;
        if (age[i] == 1 && rand_delay) delay[i] = $urandom_range(1, 5);
        if (!mute[i] && age[i] == delay[i]) begin
          UNIT_OE[i]         = 1'b1;
          fire_byte[i]       = 8'($urandom);
          UNIT_OUT[8*i +: 8] = fire_byte[i];
          fire_cyc[i]        = cyc;
        end else begin
          UNIT_OUT[8*i +: 8] = 8'($urandom);
        end
      end else begin
        age[i] = 0;
        if (junk_en && $urandom_range(0, 3) == 0) begin
          UNIT_OE[i]         = 1'b1;
          UNIT_OUT[8*i +: 8] = 8'($urandom);
        end
      end
    end
    if (rand_bp) begin
      bp         = ($urandom_range(0, 7) == 0);
      UART_FULL  = bp;
      UART_EMPTY = !bp || ($urandom_range(0, 1) == 1);
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!DONE && n < budget) begin
      cycle();
      n++;
    end
    check("done_reached", 32'(DONE), 32'd1);
    check("busy_at_fin", 32'(BUSY), 32'd0);
    check("queue_drained", exp_q.size(), 32'd0);
    check("ctr_at_fin", 32'(CTR), 32'd0);
  endtask

  task automatic stop_run();
    START = 1'b0;
    cycle();
    cycle();
    check("done_cleared", 32'(DONE), 32'd0);
    check("idle_busy", 32'(BUSY), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_ctr"}, 32'(CTR), 32'd0);
    check({pfx, "_ro_sel"}, 32'(RO_SEL), 32'd0);
    check({pfx, "_dout"}, 32'(DOUT), 32'd0);
    check({pfx, "_dtag"}, 32'(DTAG), 32'd0);
    check({pfx, "_oe"}, 32'(OE), 32'd0);
    check({pfx, "_busy"}, 32'(BUSY), 32'd0);
    check({pfx, "_done"}, 32'(DONE), 32'd0);
    check({pfx, "_fault"}, 32'(FAULT), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int oe0, n, hi, init, last;
    bit seen;
    checks = 0; errors = 0; cyc = 0; oe_cnt = 0;
    rand_delay = 0; rand_bp = 0; junk_en = 0;
    for (int i = 0; i < N; i++) begin
      delay[i] = 3; mute[i] = 0; age[i] = 0; fire_cyc[i] = 0; fire_byte[i] = '0;
    end
    RST = 1'b1; START = 1'b0; FIXED = 1'b0;
    SEL_INIT = '0; SEL_LAST = '0; SAMPLES = '0;
    UNIT_OE = '0; UNIT_OUT = '0; UART_FULL = 1'b0; UART_EMPTY = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check_all_zero("reset");
    @(negedge CLK);
    RST = 1'b0;
    cycle();

    // Directed sweep: two RO_SEL values, two rounds each
    SAMPLES = 12'd1; SEL_INIT = 20'd5; SEL_LAST = 20'd6; FIXED = 1'b0;
    expect_run(5, 6, 1, 0, -1);
    oe0 = oe_cnt;
    START = 1'b1;
    wait_done(500);
    check("t1_oe_count", oe_cnt - oe0, 32'd16);
    check("t1_fault", 32'(FAULT), 32'd0);
    stop_run();

    // Back-pressure after unit 2's write
    SAMPLES = 12'd0; SEL_INIT = 20'd9; SEL_LAST = 20'd9;
    expect_run(9, 9, 0, 0, -1);
    oe0 = oe_cnt; seen = 0; n = 0;
    START = 1'b1;
    while (!DONE && n < 500) begin
      cycle();
      n++;
      if (OE && DTAG == 3'd2 && !seen) begin
        seen = 1;
        UART_FULL = 1'b1; UART_EMPTY = 1'b0;
        for (int k = 0; k < 50; k++) begin
          if (k == 45) UART_EMPTY = 1'b1;
          cycle();
          check("t2_ctr_quiet", 32'(CTR), 32'd0);
        end
        UART_FULL = 1'b0; UART_EMPTY = 1'b1;
        cycle();
        check("t2_ctr_step", 32'(CTR), 32'd0);
        cycle();
        check("t2_ctr_arm", 32'(CTR), 32'd0);
        cycle();
        check("t2_ctr_unit3", 32'(CTR), 32'b1000);
      end
    end
    check("t2_drain_seen", 32'(seen), 32'd1);
    wait_done(100);
    check("t2_oe_count", oe_cnt - oe0, 32'd4);
    stop_run();

    // FIXED run aborted while unit 1 oscillates
    FIXED = 1'b1; SEL_INIT = 20'h00ABC; SEL_LAST = 20'h00ABD; SAMPLES = 12'd0;
    expect_run(32'hABC, 32'hABD, 0, 1, -1);
    START = 1'b1;
    n = 0;
    while (!CTR[1] && n < 100) begin cycle(); n++; end
    check("t3_unit1_osc", 32'(CTR), 32'b0010);
    START = 1'b0;
    oe0 = oe_cnt; n = 0;
    while (oe_cnt == oe0 && n < 50) begin cycle(); n++; end
    check("t3_last_byte", oe_cnt - oe0, 32'd1);
    cycle();
    cycle();
    check("t3_busy_low", 32'(BUSY), 32'd0);
    check("t3_ro_sel_kept", 32'(RO_SEL), 32'hABC);
    repeat (10) cycle();
    check("t3_no_more_oe", oe_cnt - oe0, 32'd1);
    check("t3_ctr_idle", 32'(CTR), 32'd0);
    exp_q.delete();
    FIXED = 1'b0;

    // RO_SEL wrap through zero
    SEL_INIT = 20'hFFFFF; SEL_LAST = 20'd1; SAMPLES = 12'd0;
    expect_run(32'hFFFFF, 1, 0, 0, -1);
    oe0 = oe_cnt;
    START = 1'b1;
    wait_done(500);
    check("t5_oe_count", oe_cnt - oe0, 32'd12);
    check("t5_final_sel", 32'(RO_SEL), 32'd1);
    stop_run();

`ifdef TERO_SCHED_TIMEOUT_EN
    // Silent unit 2 must be skipped after the watchdog limit
    mute[2] = 1;
    SEL_INIT = 20'd3; SEL_LAST = 20'd3; SAMPLES = 12'd0;
    expect_run(3, 3, 0, 0, 2);
    oe0 = oe_cnt; hi = 0; n = 0;
    START = 1'b1;
    while (!DONE && n < 1000) begin
      cycle();
      n++;
      if (CTR[2]) hi++;
    end
    check("t4_osc_cycles", hi, TO);
    check("t4_fault", 32'(FAULT), 32'b0100);
    wait_done(10);
    check("t4_oe_count", oe_cnt - oe0, 32'd3);
    stop_run();
    mute[2] = 0;
`endif

    // Randomized sweeps with jittered units, junk strobes and back-pressure
    rand_delay = 1; rand_bp = 1; junk_en = 1;
    for (int it = 0; it < 6; it++) begin
      init = (it == 0) ? 32'hFFFFE : ($urandom & 32'hFFFFF);
      last = (init + $urandom_range(0, 2)) & 32'hFFFFF;
      SEL_INIT = SW'(init); SEL_LAST = SW'(last);
      SAMPLES = 12'($urandom_range(0, 2));
      expect_run(init, last, int'(SAMPLES), 0, -1);
      n = exp_q.size();
      oe0 = oe_cnt;
      START = 1'b1;
      wait_done(4000);
      check("rand_oe_count", oe_cnt - oe0, n);
      check("rand_fault", 32'(FAULT), 32'd0);
      stop_run();
    end
    rand_delay = 0; rand_bp = 0; junk_en = 0;
    UART_FULL = 1'b0; UART_EMPTY = 1'b1;
    for (int i = 0; i < N; i++) delay[i] = 3;

    // Asynchronous reset while a byte is being emitted
    FIXED = 1'b1; SEL_INIT = 20'd7; SEL_LAST = 20'd7;
    expect_run(7, 7, 0, 1, -1);
    START = 1'b1;
    n = 0;
    while (!OE && n < 100) begin cycle(); n++; end
    check("t6_in_emit", 32'(OE), 32'd1);
    #2;
    RST = 1'b1;
    START = 1'b0;
    #1;
    check_all_zero("t6_async");
    @(negedge CLK);
    RST = 1'b0;
    oe0 = oe_cnt;
    repeat (20) cycle();
    check("t6_no_oe", oe_cnt - oe0, 32'd0);
    check("t6_busy", 32'(BUSY), 32'd0);
    exp_q.delete();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tero_sched.md
# tero_sched

Round-robin scheduler that sequences several TERO RNG units sharing one `seripara`/`uartsender` output path. It performs these steps:

- Fires one oscillation at a time via per-unit `CTR`.
- Captures the finishing unit's 8-bit result and forwards it, tagged with the unit index, as a single-cycle write.
- Pauses on UART back-pressure.
- Steps a shared `RO_SEL` through a programmed range after a programmed number of samples.

It sits between the `tero_rng` instances and the serializer in the evaluation top.

## Interface
- `NUM_UNIT`, 4: number of TERO units (2..8).
- `SEL_W`, 20: `RO_SEL` width.
- `TIMEOUT`, 4095: OSC watchdog limit in cycles; used only with the configuration macro.
- `CLK` in 1: 100 MHz clock.
- `RST` in 1: reset, asynchronous, active-high.
- `START` in 1: level; run request.
- `FIXED` in 1: 1 = hold `RO_SEL`; 0 = sweep.
- `SEL_INIT` in `SEL_W`: first `RO_SEL` value.
- `SEL_LAST` in `SEL_W`: last `RO_SEL` value.
- `SAMPLES` in 12: rounds per `RO_SEL` value, minus 1.
- `UNIT_OE` in `NUM_UNIT`: per-unit result strobe.
- `UNIT_OUT` in `8*NUM_UNIT`: per-unit results; unit i occupies `[8i+7:8i]`.
- `UART_FULL` in 1; `UART_EMPTY` in 1: FIFO status from `uartsender`.
- `CTR` out `NUM_UNIT`: oscillation enable, at most one bit high.
- `RO_SEL` out `SEL_W`: shared configuration.
- `DOUT` out 8; `DTAG` out 3: data and unit index.
- `OE` out 1: one-cycle write strobe to `seripara`.
- `BUSY` out 1; `DONE` out 1; `FAULT` out `NUM_UNIT`: sticky per-unit timeout flags.

## Operation
- Reset value of every output is 0.
- State **IDLE**:
  - `BUSY`=0.
  - When `START`=1: `RO_SEL`<=`SEL_INIT`, unit index u<=0, round counter r<=0, `FAULT`<=0, next state ARM.
- State **ARM**: 1 cycle with `CTR`=0, which guarantees a rising edge. Next state OSC.
- State **OSC**:
  - `CTR[u]`=1. All other `UNIT_OE` bits and `UNIT_OUT` slices are ignored.
  - On `UNIT_OE[u]`: latch `UNIT_OUT[u]` into `DOUT`, u into `DTAG`, next state EMIT.
- State **EMIT**:
  - `OE`=1 for exactly this cycle.
  - Next state is DRAIN if `UART_FULL`=1, otherwise STEP.
- State **DRAIN**: wait for `UART_EMPTY`=1, then go to STEP. If `UART_FULL` and `UART_EMPTY` are both high, FULL wins.
- State **STEP**: advance bookkeeping.
  - u<=u+1, wrapping at `NUM_UNIT`−1 to 0.
  - On wrap: r<=r+1.
  - If `START`=0, next state IDLE. This is the only point a run aborts; a sample in flight always completes.
  - Else, if wrap and r==`SAMPLES` and `FIXED`=0, next state NEXT.
  - Else next state ARM.
- State **NEXT**:
  - If `RO_SEL`==`SEL_LAST`, next state FIN.
  - Else `RO_SEL`<=`RO_SEL`+1, modulo 2^`SEL_W`, r<=0, next state ARM.
  - `SEL_INIT`>`SEL_LAST` therefore wraps through zero.
- State **FIN**: `DONE`=1, `BUSY`=0. Hold until `START`=0, then go to IDLE.
- `BUSY`=1 in ARM, OSC, EMIT, DRAIN, STEP and NEXT.
- With `FIXED`=1, `SAMPLES` is ignored and the run repeats until `START` falls.
- `FIXED`, `SEL_LAST` and `SAMPLES` are read live; `SEL_INIT` is read only in IDLE.

## Timing
- `UNIT_OE[u]` seen at cycle t: `CTR[u]` falls and `DOUT`/`DTAG` are valid at t+1, with `OE`=1 at t+1.
- `CTR` drop is registered: it falls in the cycle after OSC exits.
- Minimum period per sample with no back-pressure: ARM + OSC(≥1) + EMIT + STEP = 4 cycles.
- `DOUT`/`DTAG` hold until the next EMIT.
- Asynchronous `RST` mid-run forces IDLE and all-zero outputs immediately; no partial byte is emitted.

## Configuration
- `TERO_SCHED_TIMEOUT_EN` defined:
  - An OSC cycle counter clears on OSC entry.
  - When it reaches `TIMEOUT` without `UNIT_OE[u]`: set `FAULT[u]`, skip EMIT (no `OE`), go to STEP.
- `TERO_SCHED_TIMEOUT_EN` undefined:
  - OSC waits indefinitely.
  - `FAULT` is tied 0 and the counter is absent.

## Structure
- Shared package `tero_pkg` holds:
  - The state encoding, as 3-bit localparams IDLE..FIN.
  - The tag width.
  - The default `TIMEOUT`.
- One sub-module, `tero_watchdog` (clear, enable, limit → expire pulse), is instantiated only under the macro.
- The FSM, index counters and `RO_SEL` register live in `tero_sched`.

## Test plan
1. `NUM_UNIT`=4, `SAMPLES`=1, `SEL_INIT`=5, `SEL_LAST`=6, `FIXED`=0, model units answer 3 cycles after `CTR`.
   - Expect 16 `OE` pulses with `DTAG` order 0,1,2,3 repeated.
   - `RO_SEL` reads 5 for the first 8 pulses and 6 for the last 8, then `DONE`=1.
2. `UART_FULL` raised during EMIT of unit 2, `UART_EMPTY` raised 50 cycles later.
   - No `CTR` activity during the wait.
   - Unit 3 is armed 2 cycles after `UART_EMPTY`.
3. `FIXED`=1, `START` dropped while unit 1 is in OSC.
   - Unit 1's byte is still emitted, then IDLE with `BUSY`=0.
   - `RO_SEL` is unchanged.
4. Build with the macro and `TIMEOUT`=100; unit 2 never answers.
   - `FAULT`=4'b0100 after 100 OSC cycles, with no `OE` for unit 2.
   - Unit 3 proceeds normally.
5. `SEL_INIT`=20'hFFFFF, `SEL_LAST`=1.
   - `RO_SEL` sequence is FFFFF, 00000, 00001, then `DONE`.
6. `RST` pulse asserted asynchronously in EMIT.
   - All outputs are 0 before the next `CLK` edge; no `OE` follows.
